// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: stall vector, load-use detection,
// taken-branch redirect sequencing around in-flight fetches, and statistics counters.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stall_req,
   input  logic        mem_stall_req,
   input  logic        if_fetch_busy,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd_addr,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_read,
   input  logic        id_rs2_read,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   output logic [5:0]  stall,
   output logic        branch_enable,
   output logic        if_discard,
   output logic        pc_redirect_valid,
   output logic [31:0] pc_redirect_target,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   // state      | meaning
   // IDLE       | normal flow; taken branches from EX are accepted here
   // WAIT_FETCH | fetch in flight is discarded; redirect issued the cycle it finishes
   // REDIRECT   | PC reload pulse for a branch accepted with the fetch idle
   typedef enum logic [1:0] {IDLE, WAIT_FETCH, REDIRECT} state_t;

   state_t     state, state_nxt;
   logic       lu;
   logic       accept;
   logic [5:0] stall_raw;
   logic       be_c, discard_c, redirect_c;

   always_comb begin
      lu = 1'b0;
      if (state == IDLE && ex_is_load && ex_rd_addr != 5'd0)
         lu = (id_rs1_read && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_read && id_rs2_addr == ex_rd_addr);
   end

   always_comb begin
      stall_raw = 6'b000000;
      if (mem_stall_req)
         stall_raw = 6'b011111;
      else if (lu)
         stall_raw = 6'b000111;
      else if (if_stall_req)
         stall_raw = 6'b000011;
   end

   // Combinational outputs are forced low while reset is held
   assign stall  = rst ? 6'b000000 : stall_raw;
   assign accept = !rst && (state == IDLE) && ex_branch_taken && !stall_raw[3];

   always_comb begin
      state_nxt  = state;
      be_c       = 1'b0;
      discard_c  = 1'b0;
      redirect_c = 1'b0;
      case (state)
         IDLE: begin
            be_c = accept;
            if (accept)
               state_nxt = if_fetch_busy ? WAIT_FETCH : REDIRECT;
         end
         WAIT_FETCH: begin
            be_c = 1'b1;
            if (if_fetch_busy) begin
               discard_c = 1'b1;
            end else begin
               redirect_c = 1'b1;
               state_nxt  = IDLE;
            end
         end
         REDIRECT: begin
            be_c       = 1'b1;
            redirect_c = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign branch_enable     = be_c;
   assign if_discard        = discard_c;
   assign pc_redirect_valid = redirect_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         pc_redirect_target <= 32'd0;
         stall_cycles       <= 32'd0;
         flush_count        <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pc_redirect_target <= ex_branch_target;
            if (flush_count != 32'hFFFF_FFFF)
               flush_count <= flush_count + 32'd1;
         end
         if (stall != 6'b000000 && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change 1 time unit after posedge,
// outputs are checked 1 unit later in the same cycle.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_stall_req, mem_stall_req, if_fetch_busy, ex_is_load;
   logic [4:0]  ex_rd_addr, id_rs1_addr, id_rs2_addr;
   logic        id_rs1_read, id_rs2_read, ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic [5:0]  stall;
   logic        branch_enable, if_discard, pc_redirect_valid;
   logic [31:0] pc_redirect_target, stall_cycles, flush_count;

   int total = 0;
   int bad   = 0;

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req),
      .if_fetch_busy(if_fetch_busy), .ex_is_load(ex_is_load),
      .ex_rd_addr(ex_rd_addr), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
      .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
      .stall(stall), .branch_enable(branch_enable), .if_discard(if_discard),
      .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      if_stall_req = 0; mem_stall_req = 0; if_fetch_busy = 0; ex_is_load = 0;
      ex_rd_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0;
      id_rs1_read = 0; id_rs2_read = 0; ex_branch_taken = 0; ex_branch_target = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      mem_stall_req = 1; if_stall_req = 1; ex_branch_taken = 1; ex_branch_target = 32'h40;
      #1;
      total++; if (stall !== 6'b000000) begin bad++; $display("FAIL reset_stall got=%b exp=%b", stall, 6'b000000); end
      total++; if (branch_enable !== 1'b0) begin bad++; $display("FAIL reset_be got=%b exp=0", branch_enable); end
      next_cycle();
      total++; if (pc_redirect_target !== 32'd0) begin bad++; $display("FAIL reset_target got=%h exp=0", pc_redirect_target); end
      total++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
      clear_inputs();
      rst = 0;
      next_cycle();
   endtask

   task automatic test_load_use();
      do_reset();
      ex_is_load = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_rs2_read = 1;
      #1;
      total++; if (stall !== 6'b000111) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", stall, 6'b000111); end
      next_cycle();
      ex_rd_addr = 0; id_rs2_addr = 0;
      #1;
      total++; if (stall !== 6'b000000) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", stall, 6'b000000); end
      next_cycle();
      ex_rd_addr = 7; id_rs1_addr = 7; id_rs1_read = 0; id_rs2_addr = 3;
      #1;
      total++; if (stall !== 6'b000000) begin bad++; $display("FAIL lu_noread got=%b exp=%b", stall, 6'b000000); end
      next_cycle();
      id_rs1_read = 1;
      #1;
      total++; if (stall !== 6'b000111) begin bad++; $display("FAIL lu_rs1 got=%b exp=%b", stall, 6'b000111); end
      next_cycle();
      clear_inputs();
      #1;
      total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL lu_stall_cycles got=%0d exp=2", stall_cycles); end
   endtask

   task automatic test_priority();
      do_reset();
      mem_stall_req = 1; if_stall_req = 1;
      ex_is_load = 1; ex_rd_addr = 9; id_rs1_addr = 9; id_rs1_read = 1;
      #1;
      total++; if (stall !== 6'b011111) begin bad++; $display("FAIL prio_mem got=%b exp=%b", stall, 6'b011111); end
      next_cycle();
      mem_stall_req = 0;
      #1;
      total++; if (stall !== 6'b000111) begin bad++; $display("FAIL prio_lu got=%b exp=%b", stall, 6'b000111); end
      next_cycle();
      ex_is_load = 0;
      #1;
      total++; if (stall !== 6'b000011) begin bad++; $display("FAIL prio_if got=%b exp=%b", stall, 6'b000011); end
      next_cycle();
      clear_inputs();
      #1;
      total++; if (stall !== 6'b000000) begin bad++; $display("FAIL prio_none got=%b exp=%b", stall, 6'b000000); end
      total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL prio_stall_cycles got=%0d exp=3", stall_cycles); end
   endtask

   task automatic test_branch_idle();
      do_reset();
      ex_branch_taken = 1; ex_branch_target = 32'h0000_1040;
      #1;
      total++; if (branch_enable !== 1'b1) begin bad++; $display("FAIL bi_be_T got=%b exp=1", branch_enable); end
      total++; if (pc_redirect_valid !== 1'b0) begin bad++; $display("FAIL bi_pcrv_T got=%b exp=0", pc_redirect_valid); end
      next_cycle();
      ex_branch_taken = 0; ex_branch_target = 0;
      #1;
      total++; if (pc_redirect_valid !== 1'b1) begin bad++; $display("FAIL bi_pcrv_T1 got=%b exp=1", pc_redirect_valid); end
      total++; if (pc_redirect_target !== 32'h0000_1040) begin bad++; $display("FAIL bi_target got=%h exp=%h", pc_redirect_target, 32'h0000_1040); end
      total++; if (flush_count !== 32'd1) begin bad++; $display("FAIL bi_flush got=%0d exp=1", flush_count); end
      total++; if (branch_enable !== 1'b1 || if_discard !== 1'b0) begin bad++; $display("FAIL bi_be_T1 got=%b%b exp=10", branch_enable, if_discard); end
      next_cycle();
      #1;
      total++; if (pc_redirect_valid !== 1'b0 || branch_enable !== 1'b0) begin bad++; $display("FAIL bi_T2 got=%b%b exp=00", pc_redirect_valid, branch_enable); end
   endtask

   task automatic test_branch_fetch();
      do_reset();
      ex_branch_taken = 1; ex_branch_target = 32'h0000_2000; if_fetch_busy = 1;
      #1;
      total++; if (branch_enable !== 1'b1) begin bad++; $display("FAIL bf_be_T got=%b exp=1", branch_enable); end
      next_cycle();
      ex_branch_taken = 0;
      #1;
      total++; if (if_discard !== 1'b1 || branch_enable !== 1'b1 || pc_redirect_valid !== 1'b0) begin bad++; $display("FAIL bf_T1 got=%b%b%b exp=110", if_discard, branch_enable, pc_redirect_valid); end
      next_cycle();
      ex_branch_taken = 1; ex_branch_target = 32'h0000_3000;
      #1;
      total++; if (if_discard !== 1'b1 || pc_redirect_valid !== 1'b0) begin bad++; $display("FAIL bf_T2 got=%b%b exp=10", if_discard, pc_redirect_valid); end
      next_cycle();
      ex_branch_taken = 0;
      #1;
      total++; if (if_discard !== 1'b1 || branch_enable !== 1'b1) begin bad++; $display("FAIL bf_T3 got=%b%b exp=11", if_discard, branch_enable); end
      next_cycle();
      if_fetch_busy = 0;
      #1;
      total++; if (if_discard !== 1'b0 || pc_redirect_valid !== 1'b1) begin bad++; $display("FAIL bf_T4 got=%b%b exp=01", if_discard, pc_redirect_valid); end
      total++; if (pc_redirect_target !== 32'h0000_2000) begin bad++; $display("FAIL bf_target got=%h exp=%h", pc_redirect_target, 32'h0000_2000); end
      next_cycle();
      #1;
      total++; if (pc_redirect_valid !== 1'b0 || branch_enable !== 1'b0) begin bad++; $display("FAIL bf_T5 got=%b%b exp=00", pc_redirect_valid, branch_enable); end
      total++; if (flush_count !== 32'd1) begin bad++; $display("FAIL bf_flush got=%0d exp=1", flush_count); end
   endtask

   task automatic test_mem_hold();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         mem_stall_req = 1; ex_branch_taken = 1; ex_branch_target = 32'h0000_0044;
         #1;
         total++; if (branch_enable !== 1'b0 || stall !== 6'b011111) begin bad++; $display("FAIL mh_held%0d got=%b/%b exp=0/011111", i, branch_enable, stall); end
         next_cycle();
      end
      mem_stall_req = 0;
      #1;
      total++; if (branch_enable !== 1'b1) begin bad++; $display("FAIL mh_accept got=%b exp=1", branch_enable); end
      next_cycle();
      ex_branch_taken = 0;
      #1;
      total++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h0000_0044) begin bad++; $display("FAIL mh_redirect got=%b/%h exp=1/00000044", pc_redirect_valid, pc_redirect_target); end
      total++; if (flush_count !== 32'd1) begin bad++; $display("FAIL mh_flush got=%0d exp=1", flush_count); end
   endtask

   task automatic test_branch_lu();
      do_reset();
      ex_is_load = 1; ex_rd_addr = 12; id_rs2_addr = 12; id_rs2_read = 1;
      ex_branch_taken = 1; ex_branch_target = 32'h0000_0080;
      #1;
      total++; if (stall !== 6'b000111 || branch_enable !== 1'b1) begin bad++; $display("FAIL blu_T got=%b/%b exp=000111/1", stall, branch_enable); end
      next_cycle();
      clear_inputs();
      #1;
      total++; if (pc_redirect_valid !== 1'b1 || flush_count !== 32'd1) begin bad++; $display("FAIL blu_T1 got=%b/%0d exp=1/1", pc_redirect_valid, flush_count); end
   endtask

   task automatic test_saturation();
      do_reset();
      force dut.stall_cycles = 32'hFFFF_FFFE;
      release dut.stall_cycles;
      if_stall_req = 1;
      next_cycle();
      #1;
      total++; if (stall_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffffffff", stall_cycles); end
      next_cycle();
      next_cycle();
      #1;
      total++; if (stall_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_cycles); end
      clear_inputs();
   endtask

   task automatic test_reset_midwait();
      do_reset();
      ex_branch_taken = 1; ex_branch_target = 32'h0000_5000; if_fetch_busy = 1;
      next_cycle();
      ex_branch_taken = 0;
      #1;
      total++; if (if_discard !== 1'b1) begin bad++; $display("FAIL rw_wait got=%b exp=1", if_discard); end
      #2;
      rst = 1; mem_stall_req = 1; ex_branch_taken = 1;
      #1;
      total++; if (stall !== 6'd0 || branch_enable !== 1'b0 || if_discard !== 1'b0 || pc_redirect_valid !== 1'b0) begin bad++; $display("FAIL rw_async_outs got=%b/%b%b%b exp=000000/000", stall, branch_enable, if_discard, pc_redirect_valid); end
      total++; if (pc_redirect_target !== 32'd0 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin bad++; $display("FAIL rw_async_regs got=%h/%0d/%0d exp=0/0/0", pc_redirect_target, stall_cycles, flush_count); end
      next_cycle();
      rst = 0; clear_inputs();
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (pc_redirect_valid !== 1'b0 || if_discard !== 1'b0) begin bad++; $display("FAIL rw_after%0d got=%b%b exp=00", i, pc_redirect_valid, if_discard); end
         next_cycle();
      end
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_load_use();
      test_priority();
      test_branch_idle();
      test_branch_fetch();
      test_mem_hold();
      test_branch_lu();
      test_saturation();
      test_reset_midwait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
